prewish_mask_receiver: RTL and testbench
========================================

# prewish_mask_receiver

Responder end of the prewish strobe/data link. Accepts masks presented as `STB_I`/`DAT_I` by a mentor, turns every strobe assertion (however long) into exactly one write, acknowledges it, and buffers masks in a small first-word-fall-through queue. A display student (e.g. the blinky) drains the queue at its own pace. Overflow is counted, never blocking.

## Interface
Parameters:
- `DAT_W`, 8: mask width.
- `DEPTH_BITS`, 2: queue depth is 2**DEPTH_BITS (default 4 entries).
- `DROP_W`, 8: drop counter width.

Ports:
- `CLK_I` in 1: system clock; all logic on its rising edge.
- `RST_I` in 1: synchronous, active-high reset.
- `STB_I` in 1: strobe from mentor; level, any length ≥1 cycle.
- `DAT_I` in DAT_W: mask; sampled in the cycle STB_I first goes high.
- `ACK_O` out 1: one-cycle pulse, mask accepted.
- `ERR_O` out 1: one-cycle pulse, mask dropped (queue full).
- `mask_o` out DAT_W: head of queue; 0 when empty.
- `mask_vld_o` out 1: queue non-empty.
- `mask_take_i` in 1: consumer pops head when high with `mask_vld_o`.
- `level_o` out DEPTH_BITS+1: entries currently held, 0..2**DEPTH_BITS.
- `drop_ct_o` out DROP_W: saturating count of dropped masks.

## Operation
- Edge detect: register `stb_q <= STB_I`; `stb_rise = STB_I & ~stb_q`. Only `stb_rise` writes; a strobe held N cycles is one write.
- `stb_q` resets to 1: a strobe already high when reset releases does not write; mentor must drop and re-raise.
- Write (`stb_rise`): if not full, store `DAT_I` at write pointer, pulse `ACK_O`. If full, discard, pulse `ERR_O`, `drop_ct_o` += 1 saturating at all-ones (stays 255 by default).
- Pop: `mask_take_i & mask_vld_o` advances read pointer. `mask_take_i` while empty: ignored, no state change.
- Simultaneous write and pop when full: pop frees slot, write accepted, `ACK_O` pulses, level stays at 2**DEPTH_BITS.
- Simultaneous write and `mask_take_i` when empty: take ignored, write lands, level becomes 1.
- Pointers are DEPTH_BITS wide, wrap modulo depth. Level is a separate counter: +1 on accepted write, -1 on pop, unchanged on both or neither.
- `mask_o` is combinational from storage at read pointer, gated to 0 when level is 0.

## Timing
- Reset values: `ACK_O`=0, `ERR_O`=0, `mask_vld_o`=0, `mask_o`=0, `level_o`=0, `drop_ct_o`=0, pointers 0, `stb_q`=1. Queue contents are discarded; reset mid-transfer loses every buffered mask and suppresses any pending ACK/ERR.
- `STB_I` first high in cycle k, with `DAT_I` valid in cycle k: `ACK_O` (or `ERR_O`) high in cycle k+1 only, and `mask_vld_o`/`level_o` update in cycle k+1. Latency is 1 cycle.
- Pop at edge ending cycle k: new head on `mask_o` in cycle k+1.
- Minimum strobe spacing is 2 cycles (high 1, low 1). Back-to-back rises every 2 cycles must all be accepted until full.
- `ACK_O` and `ERR_O` are never high together.

## Structure
- `prewish_pkg`: `PREWISH_DAT_W` = 8 and `PREWISH_Q_DEPTH_BITS` = 2 defaults, shared with mentor/blinky.
- Sub-module `prewish_mask_fifo`: storage, pointers, level, FWFT read, full/empty.
- Top level keeps the edge detect, ACK/ERR registers and drop counter.

## Test plan
- Reset release with `STB_I`=1 held 5 cycles, then low: no ACK, `level_o`=0. Next 1-cycle strobe with `DAT_I`=8'hA8 gives `ACK_O` pulse one cycle later, `mask_o`=8'hA8, `mask_vld_o`=1.
- Strobe held 811 cycles with `DAT_I`=8'hCA: exactly one ACK, `level_o`=1.
- Five strobes (8'h80, 8'hA0, 8'hA8, 8'hFF, 8'hD4) with no takes: 4 ACKs then 1 `ERR_O`, `drop_ct_o`=1. Pops return 80, A0, A8, FF, then `mask_vld_o`=0 and `mask_o`=0.
- Queue full while strobe and `mask_take_i` occur in the same cycle: ACK (no ERR), `level_o` stays 4, order preserved across pointer wrap.
- 300 strobes into a full queue: `drop_ct_o` saturates at 255. `mask_take_i` pulses with queue empty cause no change.
- Assert `RST_I` for 1 cycle with `level_o`=3 and a strobe rising in the same cycle: all outputs return to reset values, no ACK follows.

Source files
------------

// File: rtl/prewish_pkg.sv
// prewish_pkg: shared defaults for the prewish strobe/data link.
// Used by the mentor, the mask receiver and the blinky display so that all
// ends of the link agree on mask width and queue depth.
package prewish_pkg;

  localparam int PREWISH_DAT_W        = 8;
  localparam int PREWISH_Q_DEPTH_BITS = 2;
  localparam int PREWISH_DROP_W       = 8;

  // Outcome of one strobe; a single register makes ACK and ERR exclusive.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_e;

endpackage

// File: rtl/prewish_mask_fifo.sv
// prewish_mask_fifo: small first-word-fall-through mask queue.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (control only)
//   wr_en     : write request (one per strobe rise)
//   wr_dat    : mask to store
//   rd_en     : consumer take; ignored while empty
//   wr_ok     : write request is accepted this cycle (combinational)
//   rd_dat    : head of queue, 0 when empty
//   rd_vld    : queue non-empty
//   level     : entries held, 0..2**DEPTH_BITS
module prewish_mask_fifo
  import prewish_pkg::*;
#(
  parameter int DAT_W      = PREWISH_DAT_W,
  parameter int DEPTH_BITS = PREWISH_Q_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DAT_W-1:0]      wr_dat,
  input  logic                  rd_en,
  output logic                  wr_ok,
  output logic [DAT_W-1:0]      rd_dat,
  output logic                  rd_vld,
  output logic [DEPTH_BITS:0]   level
);

  localparam int                  DEPTH   = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_L = (DEPTH_BITS + 1)'(DEPTH);

  logic [DAT_W-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   lvl;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full  = (lvl == DEPTH_L);
  assign empty = (lvl == '0);
  assign pop   = rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push  = wr_en & (~full | pop);

  // Storage holds data only; no reset, stale entries are hidden by the level gate.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

  assign wr_ok  = push;
  assign rd_vld = ~empty;
  assign rd_dat = empty ? '0 : mem[rd_ptr];
  assign level  = lvl;

endmodule

// File: rtl/prewish_mask_receiver.sv
// prewish_mask_receiver: responder end of the prewish strobe/data link.
// Every rising edge of STB_I becomes one write of DAT_I into a FWFT queue;
// the outcome is reported one cycle later on ACK_O (stored) or ERR_O
// (queue full, dropped). Drops are counted with saturation.
// Ports:
//   CLK_I, RST_I : clock, synchronous active-high reset
//   STB_I, DAT_I : strobe level and mask from the mentor
//   ACK_O, ERR_O : one-cycle accept / drop pulses
//   mask_o, mask_vld_o, mask_take_i : queue head, non-empty, consumer pop
//   level_o      : entries held
//   drop_ct_o    : saturating count of dropped masks
module prewish_mask_receiver
  import prewish_pkg::*;
#(
  parameter int DAT_W      = PREWISH_DAT_W,
  parameter int DEPTH_BITS = PREWISH_Q_DEPTH_BITS,
  parameter int DROP_W     = PREWISH_DROP_W
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                STB_I,
  input  logic [DAT_W-1:0]    DAT_I,
  output logic                ACK_O,
  output logic                ERR_O,
  output logic [DAT_W-1:0]    mask_o,
  output logic                mask_vld_o,
  input  logic                mask_take_i,
  output logic [DEPTH_BITS:0] level_o,
  output logic [DROP_W-1:0]   drop_ct_o
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              stb_q;
  logic              stb_rise;
  logic              wr_ok;
  rsp_e              rsp_p1;
  logic [DROP_W-1:0] drop_ct;

  // Stage 0: edge detect. stb_q resets high so a strobe already asserted
  // when reset releases is not taken as a new write.
  assign stb_rise = STB_I & ~stb_q;

  prewish_mask_fifo #(
    .DAT_W      (DAT_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk    (CLK_I),
    .rst    (RST_I),
    .wr_en  (stb_rise),
    .wr_dat (DAT_I),
    .rd_en  (mask_take_i),
    .wr_ok  (wr_ok),
    .rd_dat (mask_o),
    .rd_vld (mask_vld_o),
    .level  (level_o)
  );

  // Stage 1: registered response and drop counter.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      stb_q   <= 1'b1;
      rsp_p1  <= RSP_NONE;
      drop_ct <= '0;
    end else begin
      stb_q <= STB_I;
      if (stb_rise && wr_ok)      rsp_p1 <= RSP_ACK;
      else if (stb_rise)          rsp_p1 <= RSP_ERR;
      else                        rsp_p1 <= RSP_NONE;
      if (stb_rise && !wr_ok) drop_ct <= sat_inc(drop_ct);
    end
  end

  assign ACK_O     = (rsp_p1 == RSP_ACK);
  assign ERR_O     = (rsp_p1 == RSP_ERR);
  assign drop_ct_o = drop_ct;

endmodule

// File: tb/tb_prewish_mask_receiver.sv
module tb_prewish_mask_receiver;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       mask_take_i = 1'b0;
  logic       ACK_O;
  logic       ERR_O;
  logic [7:0] mask_o;
  logic       mask_vld_o;
  logic [2:0] level_o;
  logic [7:0] drop_ct_o;

  always #5 CLK_I = ~CLK_I;

  prewish_mask_receiver dut (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .STB_I       (STB_I),
    .DAT_I       (DAT_I),
    .ACK_O       (ACK_O),
    .ERR_O       (ERR_O),
    .mask_o      (mask_o),
    .mask_vld_o  (mask_vld_o),
    .mask_take_i (mask_take_i),
    .level_o     (level_o),
    .drop_ct_o   (drop_ct_o)
  );

  // Reference model: queue of masks, last strobe level, expected pulses.
  logic [7:0] mq[$];
  bit         m_prev = 1'b1;
  bit         m_ack  = 1'b0;
  bit         m_err  = 1'b0;
  int         m_drop = 0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    else
      n_pass++;
  endtask

  task automatic check_model();
    check("ack",   32'(ACK_O),      32'(m_ack));
    check("err",   32'(ERR_O),      32'(m_err));
    check("vld",   32'(mask_vld_o), 32'(mq.size() > 0));
    check("mask",  32'(mask_o),     (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    check("level", 32'(level_o),    32'(mq.size()));
    check("drop",  32'(drop_ct_o),  32'(m_drop));
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare 1 time unit later.
  task automatic step(input logic stb, input logic [7:0] dat, input logic take, input logic rst);
    bit rise, acc;
    @(negedge CLK_I);
    STB_I = stb; DAT_I = dat; mask_take_i = take; RST_I = rst;
    @(posedge CLK_I);
    if (rst) begin
      mq.delete();
      m_prev = 1'b1; m_ack = 1'b0; m_err = 1'b0; m_drop = 0;
    end else begin
      rise   = stb && !m_prev;
      m_prev = stb;
      if (take && mq.size() > 0) void'(mq.pop_front());
      acc = rise && (mq.size() < 4);
      if (acc) mq.push_back(dat);
      m_ack = acc;
      m_err = rise && !acc;
      if (m_err && m_drop < 255) m_drop++;
    end
    #1;
    check_model();
  endtask

  task automatic strobe(input logic [7:0] dat, input logic take);
    step(1'b1, dat, take, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] five [5] = '{8'h80, 8'hA0, 8'hA8, 8'hFF, 8'hD4};
  logic [7:0] wrap_exp [4] = '{8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    int ack_cnt;
    int err_cnt;

    // Reset, then release with strobe already high.
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    check("rst_level", 32'(level_o), 32'd0);
    ack_cnt = 0;
    repeat (5) begin
      step(1'b1, 8'h55, 1'b0, 1'b0);
      ack_cnt += int'(ACK_O);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("held_rst_acks", 32'(ack_cnt), 32'd0);
    check("held_rst_level", 32'(level_o), 32'd0);

    // First real strobe.
    step(1'b1, 8'hA8, 1'b0, 1'b0);
    check("a8_ack", 32'(ACK_O), 32'd1);
    check("a8_mask", 32'(mask_o), 32'hA8);
    check("a8_vld", 32'(mask_vld_o), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("a8_ack_once", 32'(ACK_O), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Long strobe: one write only.
    ack_cnt = 0;
    repeat (811) begin
      step(1'b1, 8'hCA, 1'b0, 1'b0);
      ack_cnt += int'(ACK_O);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("long_acks", 32'(ack_cnt), 32'd1);
    check("long_level", 32'(level_o), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Five strobes into a 4-deep queue.
    ack_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, five[i], 1'b0, 1'b0);
      ack_cnt += int'(ACK_O);
      err_cnt += int'(ERR_O);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    check("five_acks", 32'(ack_cnt), 32'd4);
    check("five_errs", 32'(err_cnt), 32'd1);
    check("five_drop", 32'(drop_ct_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("five_pop", 32'(mask_o), 32'(five[i]));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained_vld", 32'(mask_vld_o), 32'd0);
    check("drained_mask", 32'(mask_o), 32'd0);

    // Full queue, write and take together, across pointer wrap.
    strobe(8'h11, 1'b0); strobe(8'h22, 1'b0);
    strobe(8'h33, 1'b0); strobe(8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_rw_ack", 32'(ACK_O), 32'd1);
    check("full_rw_err", 32'(ERR_O), 32'd0);
    check("full_rw_level", 32'(level_o), 32'd4);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    strobe(8'h66, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("wrap_order", 32'(mask_o), 32'(wrap_exp[i]));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Saturating drop counter.
    for (int i = 0; i < 4; i++) strobe(8'(i + 1), 1'b0);
    repeat (300) strobe(8'hEE, 1'b0);
    check("drop_sat", 32'(drop_ct_o), 32'd255);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (5) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("empty_take_level", 32'(level_o), 32'd0);
    end
    check("empty_take_drop", 32'(drop_ct_o), 32'd255);

    // Reset with level 3 and a strobe rising in the reset cycle.
    strobe(8'h01, 1'b0); strobe(8'h02, 1'b0); strobe(8'h03, 1'b0);
    check("pre_rst_level", 32'(level_o), 32'd3);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check("rst_ack", 32'(ACK_O), 32'd0);
    check("rst_level3", 32'(level_o), 32'd0);
    check("rst_drop", 32'(drop_ct_o), 32'd0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_rst_ack", 32'(ACK_O), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 299) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
